// File: rtl/icache_line_buffer_if.sv
// Fetch-side (imem) and refill-side (mem) signals of the instruction cache.
// slave: the cache's view. master: the fetch stage plus bus driving the cache.
interface icache_line_buffer_if;
  logic        imem_valid_i;
  logic [31:0] imem_addr_i;
  logic [31:0] imem_wdata_i;
  logic [3:0]  imem_we_i;
  logic        imem_ready_o;
  logic [31:0] imem_rdata_o;
  logic        mem_valid_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  imem_valid_i, imem_addr_i, imem_wdata_i, imem_we_i, mem_ready_i, mem_rdata_i,
    output imem_ready_o, imem_rdata_o, mem_valid_o, mem_addr_o
  );

  modport master (
    output imem_valid_i, imem_addr_i, imem_wdata_i, imem_we_i, mem_ready_i, mem_rdata_i,
    input  imem_ready_o, imem_rdata_o, mem_valid_o, mem_addr_o
  );
endinterface

// File: rtl/icache_line_buffer.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, whole-line refill on a miss.
// Define ICACHE_FLUSH_EN to add flush_i, which invalidates every line.
module icache_line_buffer #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input logic clk,
  input logic rst,
`ifdef ICACHE_FLUSH_EN
  input logic flush_i,
`endif
  icache_line_buffer_if.slave bus
);

  localparam int WB      = $clog2(WORDS_PER_LINE);
  localparam int IB      = $clog2(LINES);
  localparam int IDX_LSB = 2 + WB;
  localparam int TAG_LSB = IDX_LSB + IB;
  localparam int TAG_W   = 32 - TAG_LSB;
  localparam int LINE_W  = 32 - IDX_LSB;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_req_addr;
  logic [LINE_W-1:0] r_fill_line;
  logic [WB-1:0]     r_word_cnt;
  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [31:0]       r_data [LINES*WORDS_PER_LINE];

  logic [IB-1:0]     w_req_idx;
  logic [IB-1:0]     w_fill_idx;
  logic [WB-1:0]     w_req_word;
  logic [TAG_W-1:0]  w_req_tag;
  logic [TAG_W-1:0]  w_fill_tag;
  logic              w_hit;
  logic              w_mem_fire;
  logic              w_fill_done;
  logic              w_start_fill;
  logic              w_flush;
  logic              w_fill_blocked;
  logic              w_unused;

  assign w_req_word  = r_req_addr[IDX_LSB-1:2];
  assign w_req_idx   = r_req_addr[TAG_LSB-1:IDX_LSB];
  assign w_req_tag   = r_req_addr[31:TAG_LSB];
  assign w_fill_idx  = r_fill_line[IB-1:0];
  assign w_fill_tag  = r_fill_line[LINE_W-1:IB];
  assign w_hit       = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
  assign w_mem_fire  = (r_state == S_REFILL) && bus.mem_ready_i;
  assign w_fill_done = w_mem_fire && (r_word_cnt == WB'(WORDS_PER_LINE - 1));

  // The write port and byte offset are meaningless for a read-only cache.
  assign w_unused = ^{bus.imem_wdata_i, bus.imem_we_i, r_req_addr[1:0]};

`ifdef ICACHE_FLUSH_EN
  // A flush seen during a refill must keep that line from becoming valid.
  logic r_flush_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_flush_pend <= 1'b0;
    else if (w_start_fill) r_flush_pend <= 1'b0;
    else if (flush_i)      r_flush_pend <= 1'b1;
  end

  assign w_flush        = flush_i;
  assign w_fill_blocked = flush_i || r_flush_pend;
`else
  assign w_flush        = 1'b0;
  assign w_fill_blocked = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    w_state_nxt  = r_state;
    w_start_fill = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.imem_valid_i) w_state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (!bus.imem_valid_i) begin
          w_state_nxt = S_IDLE;
        end else if (!w_hit) begin
          w_state_nxt  = S_REFILL;
          w_start_fill = 1'b1;
        end
      end
      S_REFILL: begin
        if (w_fill_done) w_state_nxt = S_LOOKUP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_req_addr  <= '0;
      r_fill_line <= '0;
      r_word_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (bus.imem_valid_i) r_req_addr <= bus.imem_addr_i;
      if (w_start_fill) begin
        r_fill_line <= r_req_addr[31:IDX_LSB];
        r_word_cnt  <= '0;
      end else if (w_mem_fire) begin
        r_word_cnt <= r_word_cnt + WB'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_valid <= '0;
    else if (w_flush)                          r_valid <= '0;
    else if (w_start_fill)                     r_valid[w_req_idx]  <= 1'b0;
    else if (w_fill_done && !w_fill_blocked)   r_valid[w_fill_idx] <= 1'b1;
  end

  // NOTE: tag and data arrays are not reset; the valid bits alone decide
  // whether their contents are meaningful, which keeps them RAM-mappable.
  always_ff @(posedge clk) begin
    if (w_mem_fire)  r_data[{w_fill_idx, r_word_cnt}] <= bus.mem_rdata_i;
    if (w_fill_done) r_tag[w_fill_idx] <= w_fill_tag;
  end

  assign bus.imem_ready_o = (r_state == S_LOOKUP) && bus.imem_valid_i && w_hit && !w_flush;
  assign bus.imem_rdata_o = (r_state == S_LOOKUP) ? r_data[{w_req_idx, w_req_word}] : '0;
  assign bus.mem_valid_o  = (r_state == S_REFILL);
  assign bus.mem_addr_o   = (r_state == S_REFILL) ? {r_fill_line, r_word_cnt, 2'b00} : '0;

endmodule
